dual_diagonal_backsub: RTL and testbench

//  Back-substitution stage for a dual-diagonal (staircase) parity structure, as used in LDPC encoding.
//  - Each frame is NUM_WORDS words. Output word k is the running XOR of input words 0..k of that frame:
//    x[0]=y[0], x[k]=y[k]^x[k-1].
//  - Streams one output per accepted input, in input order. There is no backpressure.
//  - The accumulator clears automatically at every frame boundary.

---
 rtl/dual_diagonal_backsub.sv | 77 +++++++
 tb/tb_dual_diagonal_backsub.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dual_diagonal_backsub.sv
// Staircase back-substitution: each output is the running XOR of the frame's inputs so far.
// Optional input register stage enabled by defining DUAL_DIAG_BACKSUB_IN_REG_EN.
module dual_diagonal_backsub #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid
);

  localparam int unsigned CntW = $clog2(NUM_WORDS);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_WORDS - 1);

  logic [WIDTH-1:0] stage_data;
  logic             stage_valid;
  logic [WIDTH-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;
  logic [WIDTH-1:0] result;

`ifdef DUAL_DIAG_BACKSUB_IN_REG_EN
  logic [WIDTH-1:0] in_data_q;
  logic             in_valid_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
    end else begin
      in_data_q  <= i_in_data;
      in_valid_q <= i_in_valid;
    end
  end

  assign stage_data  = in_data_q;
  assign stage_valid = in_valid_q;
`else
  assign stage_data  = i_in_data;
  assign stage_valid = i_in_valid;
`endif

  // Word 0 of a frame ignores the accumulator, so frames never leak into each other.
  always_comb begin
    result = stage_data;
    if (cnt_q != '0) begin
      result = stage_data ^ acc_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (cnt_q == LastCnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
    end else begin
      o_out_valid <= stage_valid;
      if (stage_valid) begin
        acc_q      <= result;
        cnt_q      <= cnt_d;
        o_out_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_dual_diagonal_backsub.sv
// Randomized self-checking bench for dual_diagonal_backsub against a frame-level XOR model.
module tb_dual_diagonal_backsub;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned NUM_WORDS = 8;
`ifdef DUAL_DIAG_BACKSUB_IN_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  typedef struct {
    int             due;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_out    = 0;
  int n_exp    = 0;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] frame_words[$];
  logic [WIDTH-1:0] last_data = '0;

  dual_diagonal_backsub #(
    .WIDTH    (WIDTH),
    .NUM_WORDS(NUM_WORDS)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_in_data  (in_data),
    .i_in_valid (in_valid),
    .o_out_data (out_data),
    .o_out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference: output is the XOR of every word received so far in the current frame.
  function automatic logic [WIDTH-1:0] model_push(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] x = '0;
    frame_words.push_back(w);
    foreach (frame_words[i]) x ^= frame_words[i];
    if (frame_words.size() == NUM_WORDS) frame_words.delete();
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check("valid", 32'(out_valid), 32'd1);
        check("data", 32'(out_data), 32'(exp_q[0].data));
        last_data = exp_q[0].data;
        void'(exp_q.pop_front());
      end else begin
        check("idle_valid", 32'(out_valid), 32'd0);
        check("hold_data", 32'(out_data), 32'(last_data));
      end
      if (out_valid) n_out++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input int gap);
    exp_t e;
    in_data  = w;
    in_valid = 1'b1;
    e.due    = cyc + Lat;
    e.data   = model_push(w);
    exp_q.push_back(e);
    n_exp++;
    tick();
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    repeat (gap) tick();
  endtask

  // Asynchronous reset between clock edges; pending outputs are discarded.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    n_exp -= exp_q.size();
    exp_q.delete();
    frame_words.delete();
    last_data = '0;
    in_valid  = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    repeat (Lat + 2) tick();
  endtask

  logic [WIDTH-1:0] vec[NUM_WORDS] = '{16'd37449, 16'd56173, 16'd28086, 16'd46811,
                                       16'd56173, 16'd28086, 16'd46811, 16'd56173};
  logic [WIDTH-1:0] gold[NUM_WORDS] = '{16'd37449, 16'd18724, 16'd9362, 16'd37449,
                                        16'd18724, 16'd9362, 16'd37449, 16'd18724};

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    #12;
    rst_n = 1'b1;
    tick();

    // Idle: no spontaneous output.
    base = n_out;
    repeat (120) tick();
    check("idle_pulses", 32'(n_out - base), 32'd0);

    // All-zero frame.
    base = n_out;
    for (int i = 0; i < NUM_WORDS; i++) send('0, 0);
    drain();
    check("zero_count", 32'(n_out - base), NUM_WORDS);

    // Known frame, checked against the model and also against fixed golden values.
    for (int i = 0; i < NUM_WORDS; i++) begin
      logic [WIDTH-1:0] m;
      m = exp_q.size() == 0 ? '0 : '0;
      send(vec[i], 0);
      m = exp_q[exp_q.size() - 1].data;
      check("gold_model", 32'(m), 32'(gold[i]));
    end
    drain();

    // Back-to-back frames, then gapped frame.
    base = n_out;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NUM_WORDS; i++) send(vec[i], 0);
    drain();
    check("b2b_count", 32'(n_out - base), 2 * NUM_WORDS);
    base = n_out;
    for (int i = 0; i < NUM_WORDS; i++) send(vec[i], 1 + int'($urandom_range(2)));
    drain();
    check("gap_count", 32'(n_out - base), NUM_WORDS);

    // Mid-frame reset, then a full frame from word 0.
    for (int i = 0; i < 3; i++) send(vec[i], 0);
    do_reset();
    for (int i = 0; i < NUM_WORDS; i++) send(vec[i], 0);
    drain();

    // Random frames with random gaps and occasional resets.
    for (int w = 0; w < 300; w++) begin
      if ($urandom_range(40) == 0) do_reset();
      send(WIDTH'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0);
    end
    drain();

    check("pending_empty", 32'(exp_q.size()), 32'd0);
    check("total_outputs", 32'(n_out), 32'(n_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
